// File: rtl/toggle_burst_sched_if.sv
// ============================================================================
// Module  : toggle_burst_sched_if
// Brief   : Request/configuration/status bundle of the toggle burst scheduler.
//           master = control side, slave = scheduler side.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface toggle_burst_sched_if #(
  parameter int NREQ  = 4,
  parameter int CW    = 8,
  parameter int DIV_W = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] burst_len;
  logic [DIV_W-1:0]   div_period;
  logic [NREQ-1:0]    grant;
  logic               t_en;
  logic               q;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [CW-1:0]      toggles_left;

  modport master (
    output req, burst_len, div_period,
    input  grant, t_en, q, busy, done, aborted, toggles_left
  );

  modport slave (
    input  req, burst_len, div_period,
    output grant, t_en, q, busy, done, aborted, toggles_left
  );
endinterface

`default_nettype wire

// File: rtl/toggle_burst_sched.sv
// ============================================================================
// Module  : toggle_burst_sched
// Brief   : Round-robin scheduler sharing one divided-rate toggle resource
//           (T flip-flop + tick divider) between NREQ requesters. Each grant
//           receives a burst of toggles at a latched tick period.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module toggle_burst_sched #(
  parameter int NREQ  = 4,
  parameter int CW    = 8,
  parameter int DIV_W = 16
) (
  input  wire logic                clk,
  input  wire logic                reset,
  toggle_burst_sched_if.slave      bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NREQ-1:0]   r_grant;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [CW-1:0]     r_left;
  logic [DIV_W-1:0]  r_period;
  logic [DIV_W-1:0]  r_tick;
  logic              r_q;
  logic              r_abort;

  logic              w_found;
  logic [PW-1:0]     w_pick;
  logic [PW-1:0]     w_idx;
  logic [PW:0]       w_sum;
  logic [CW-1:0]     w_pick_len;
  logic              w_tick_hit;
  logic              w_owner_req;
  logic              w_last;
  logic              w_t_en;
  logic              w_done;
  logic              w_abort_now;

  // Round-robin search: first requesting index starting at r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_pick_len  = bus.burst_len[int'(w_pick)*CW +: CW];
  assign w_tick_hit  = (r_tick == (r_period - DIV_W'(1)));
  assign w_owner_req = bus.req[r_owner];
  assign w_last      = (r_left == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and strobes; an owner dropping req wins over a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    w_t_en      = 1'b0;
    w_done      = 1'b0;
    w_abort_now = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = (w_pick_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!w_owner_req) begin
          w_abort_now = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_tick_hit) begin
          w_t_en = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst datapath: grant/config latch, tick divider, toggle and remaining count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_left   <= '0;
      r_period <= '0;
      r_tick   <= '0;
      r_q      <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
            r_owner  <= w_pick;
            r_left   <= w_pick_len;
            r_period <= (bus.div_period == '0) ? DIV_W'(1) : bus.div_period;
            r_tick   <= '0;
            r_rr_ptr <= (w_pick == PW'(NREQ-1)) ? '0 : w_pick + 1'b1;
            r_abort  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_abort_now) begin
            r_abort <= 1'b1;
          end else if (w_t_en) begin
            r_q    <= ~r_q;
            r_tick <= '0;
            if (r_left != '0) begin
              r_left <= r_left - 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant        = r_grant;
  assign bus.t_en         = w_t_en;
  assign bus.q            = r_q;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = w_done;
  assign bus.aborted      = w_done & r_abort;
  assign bus.toggles_left = r_left;

endmodule

`default_nettype wire
